// File: rtl/alw_pkg.sv
// Shared definitions for the edge counter: default counter width and the
// rise-detector state encoding.
package alw_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } rise_state_e;

endpackage

// File: rtl/alw_rise_det.sv
// Two-flop synchronizer followed by a LOW/HIGH FSM that emits a single-cycle
// pulse for each low-to-high transition of an asynchronous level.
module alw_rise_det
  import alw_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic        s_meta_q, s_meta_d;
  logic        s_sync_q, s_sync_d;
  rise_state_e state_q, state_d;

  always_comb begin
    s_meta_d = din;
    s_sync_d = s_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
      state_q  <= LOW;
    end else begin
      s_meta_q <= s_meta_d;
      s_sync_q <= s_sync_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOW:     if (s_sync_q)  state_d = HIGH;
      HIGH:    if (!s_sync_q) state_d = LOW;
      default: state_d = LOW;
    endcase
  end

  // Pulse is combinational on the LOW->HIGH decision so the count lands one
  // edge after the synchronized level first reads high.
  always_comb begin
    rise = 1'b0;
    if (state_q == LOW && s_sync_q) rise = 1'b1;
  end

endmodule

// File: rtl/alw_edge_counter.sv
// Up/down counter stepped by rising edges on sin (up) and sin1 (down);
// simultaneous rises cancel. Arithmetic wraps modulo 2^CNT_W.
module alw_edge_counter
  import alw_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin1,
  output logic [CNT_W-1:0] cnt
);

  logic             up_rise;
  logic             dn_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alw_rise_det u_up_det (
    .clk  (clk),
    .rst  (rst),
    .din  (sin),
    .rise (up_rise)
  );

  alw_rise_det u_dn_det (
    .clk  (clk),
    .rst  (rst),
    .din  (sin1),
    .rise (dn_rise)
  );

  always_comb begin
    cnt_d = cnt_q;
    case ({up_rise, dn_rise})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_alw_edge_counter.sv
// Scoreboard bench for alw_edge_counter: expected counts are queued against
// the clock edge at which they must appear and checked on the falling edge.
`timescale 1ns/1ps
module tb_alw_edge_counter;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin1;
  logic [3:0] cnt;

  alw_edge_counter #(.CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .sin1 (sin1),
    .cnt  (cnt)
  );

  initial begin
    clk = 1'b0;
    #5;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         edge_idx = -1;
  logic [3:0] cnt_m = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int e, input logic [3:0] v);
    exp_t x;
    x.edge_n = e;
    x.val    = v;
    sb_q.push_back(x);
  endtask

  // Edge 0 is the rising edge at 5 ns; edge n is at 5 + 10*n ns.
  always @(posedge clk) edge_idx++;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_idx) begin
      exp_t x;
      x = sb_q.pop_front();
      chk($sformatf("cnt_e%0d", x.edge_n), {28'd0, cnt}, {28'd0, x.val});
    end
  end

  // Pulse starting at the current time (never on a rising edge): first sample
  // edge e, count appears at e+2, value unchanged at e+1.
  task automatic pulse(input bit up, input bit dn, input int width);
    int         t;
    int         e;
    logic [3:0] old;
    t   = int'($time);
    e   = (t - 5 + 9) / 10;
    old = cnt_m;
    if (up && !dn)      cnt_m = cnt_m + 4'd1;
    else if (dn && !up) cnt_m = cnt_m - 4'd1;
    push(e + 1, old);
    push(e + 2, cnt_m);
    sin  = up;
    sin1 = dn;
    #(width);
    sin  = 1'b0;
    sin1 = 1'b0;
  endtask

  bit [1:0] pat [10] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10,
                         2'b10, 2'b01, 2'b11, 2'b01, 2'b10};

  initial begin
    rst  = 1'b1;
    sin  = 1'b0;
    sin1 = 1'b0;
    push(1, 4'd0);
    push(2, 4'd0);
    #20 rst = 1'b0;

    #6 pulse(1'b1, 1'b0, 25);           // 26..51 ns, count at 55 ns
    push(7, 4'd1);

    #37 sin = 1'b1;                     // 88 ns
    push(10, 4'd1);
    push(11, 4'd1);
    push(12, 4'd1);
    #5 sin1 = 1'b1;                     // 93 ns
    #9 sin1 = 1'b0;                     // 102 ns
    #48 sin = 1'b0;                     // 150 ns

    #47 pulse(1'b0, 1'b1, 11);          // 197..208 ns, count at 225 ns
    #38 pulse(1'b0, 1'b1, 10);          // 0 -> 15
    #40 pulse(1'b1, 1'b0, 10);          // 15 -> 0

    #40 sin = 1'b1;                     // 346 ns, long high level
    cnt_m = 4'd1;
    push(36, 4'd0);
    push(37, 4'd1);
    push(42, 4'd1);
    push(48, 4'd1);
    #154 sin = 1'b0;                    // 500 ns

    #16 sin = 1'b1;                     // 516 ns, held across reset
    cnt_m = 4'd2;
    push(53, 4'd1);
    push(54, 4'd2);
    #40 rst = 1'b1;                     // 556 ns
    push(56, 4'd0);
    push(57, 4'd0);
    #24 rst = 1'b0;                     // 580 ns
    cnt_m = 4'd1;
    push(59, 4'd0);
    push(60, 4'd1);
    push(66, 4'd1);
    #120 sin = 1'b0;                    // 700 ns

    #46;
    for (int i = 0; i < 10; i++) begin
      pulse(pat[i][1], pat[i][0], 10);
      #50;
    end

    #100;
    chk("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alw_edge_counter.md
ALW_EDGE_COUNTER -- requirements
Module: alw_edge_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sin, input, 1 bit: up-count request level, asynchronous to clk.
REQ-005 The block SHALL have port sin1, input, 1 bit: down-count request level, asynchronous to clk.
REQ-006 The block SHALL have port cnt, output, CNT_W bits: current count, driven directly from a register.

Function
REQ-007 The block SHALL pass each of sin and sin1 through its own two-flop synchronizer (s_meta, s_sync) before any use.
REQ-008 The block SHALL detect a rise per input with a 2-state FSM (LOW, HIGH): LOW->HIGH when the synchronized level is 1, which asserts a one-cycle rise pulse; HIGH->LOW when the level is 0; otherwise hold.
REQ-009 The block SHALL produce exactly one rise pulse per low-to-high transition, however long the input stays high.
REQ-010 An input pulse high across at least one rising clk edge SHALL be counted; a pulse that spans no rising edge may be missed.
REQ-011 On a sin rise pulse alone, cnt SHALL increment by 1 on the next rising edge, wrapping from 2^CNT_W-1 to 0.
REQ-012 On a sin1 rise pulse alone, cnt SHALL decrement by 1 on the next rising edge, wrapping from 0 to 2^CNT_W-1.
REQ-013 When both rise pulses occur in the same cycle, cnt SHALL be unchanged.
REQ-014 With no rise pulse, cnt SHALL hold its value.
REQ-015 Latency: cnt SHALL change on the 3rd rising clk edge, counting the first edge that samples the input high as edge 1.
REQ-016 Arithmetic SHALL be modulo 2^CNT_W with no carry, borrow or overflow output.

Reset
REQ-017 When rst=1 at a rising edge, cnt SHALL become 0, all synchronizer flops SHALL become 0, and both edge FSMs SHALL go to LOW.
REQ-018 Reset SHALL take priority over any rise pulse in the same cycle.
REQ-019 An input already high when rst deasserts SHALL produce a rise pulse once it propagates through the synchronizer, and so SHALL be counted.
REQ-020 Reset SHALL be synchronous only; the block SHALL have no asynchronous reset path.

Structure
REQ-021 A shared package alw_pkg SHALL hold the default CNT_W value and the FSM state typedef (LOW, HIGH).
REQ-022 The synchronizer and edge FSM SHALL form one sub-module, alw_rise_det, instantiated twice (for sin and sin1).
REQ-023 The top level SHALL contain only the two instances and the up/down counter register.

Verification
The clk period is 10 ns, with the first rising edge at 5 ns.
REQ-024 rst=1 for 2 edges with sin=sin1=0 -> cnt=0 and stays 0.
REQ-025 sin goes 0->1 at 26 ns and back to 0 at 51 ns -> cnt becomes 1 at the 55 ns edge (sampled at 35/45/55), one increment only.
REQ-026 sin rises at 88 ns and sin1 pulses 93-102 ns (both first sampled at 95 ns) -> simultaneous rises, cnt stays 1.
REQ-027 sin1 pulses 197-208 ns with sin=0 -> cnt becomes 0 at the 225 ns edge.
REQ-028 From cnt=15 a single sin pulse -> cnt=0; from cnt=0 a single sin1 pulse -> cnt=15.
REQ-029 sin held high across a rst assertion -> cnt stays 0 during reset; one increment follows after the synchronizer latency; no further counts while sin stays high.
